// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: takes bytes over valid/ready and shifts them MSB-first onto the
// fabric configuration chain, generating one divided prog_clk pulse per bit.
`timescale 1ns/1ps
module fpga_cfg_loader #(
  parameter int CHAIN_LEN = 200,
  parameter int DIV       = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             prog_clk,
  output logic             ccff_head,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic [CNT_W-1:0] bits_sent
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  state_t           state;
  logic [6:0]       shreg;
  logic [2:0]       bit_idx;
  logic [DIV_W-1:0] div_cnt;
  logic             phase_end;
  logic             chain_full;
  logic             next_bit;

  // Bit counter never wraps: it stops at the chain length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LAST_BIT) ? v : v + CNT_W'(1);
  endfunction

  assign byte_ready = (state == WAIT_BYTE);
  assign phase_end  = (div_cnt == DIV_LAST);
  assign chain_full = (bits_sent == LAST_BIT);
  assign next_bit   = (state == SHIFT_HI) && phase_end && !chain_full && (bit_idx != 3'd7);

  // Only the seven not-yet-shifted bits are kept; bit 7 goes straight to ccff_head.
  always_ff @(posedge clk) begin
    if (byte_ready && byte_valid) begin
      shreg <= byte_in[6:0];
    end else if (next_bit) begin
      shreg <= {shreg[5:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_clk  <= 1'b0;
      ccff_head <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      bits_sent <= '0;
      bit_idx   <= '0;
      div_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WAIT_BYTE;
            bits_sent <= '0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
          end
        end
        WAIT_BYTE: begin
          if (byte_valid) begin
            ccff_head <= byte_in[7];
            bit_idx   <= '0;
            div_cnt   <= '0;
            state     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            prog_clk  <= 1'b1;
            bits_sent <= sat_inc(bits_sent);
            div_cnt   <= '0;
            state     <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            // Data only moves on the falling edge, giving a full low phase of setup.
            prog_clk <= 1'b0;
            div_cnt  <= '0;
            if (chain_full) begin
              state     <= DONE;
              ccff_head <= 1'b0;
              cfg_busy  <= 1'b0;
              cfg_done  <= 1'b1;
            end else if (bit_idx == 3'd7) begin
              state <= WAIT_BYTE;
            end else begin
              ccff_head <= shreg[6];
              bit_idx   <= bit_idx + 3'd1;
              state     <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
